// File: rtl/obstacle_pkg.sv
// obstacle_pkg: shared obstacle word layout, type codes and collector constants
package obstacle_pkg;
  localparam int MAX_OBSTACLES = 48;
  localparam int WORD_W = 16;
  localparam int LANES = 3;
  localparam int TYPE_LSB = 13;
  localparam int TYPE_W = 3;
  localparam int LANE_LSB = 11;
  localparam int LANE_W = 2;
  localparam int DEPTH_LSB = 0;
  localparam int DEPTH_W = 11;
  typedef logic [WORD_W-1:0] obstacle_t;
  typedef enum logic [TYPE_W-1:0] {
    OBS_NONE, OBS_LOW, OBS_HIGH, OBS_MIDDLE, OBS_TRAIN, OBS_RAMP, OBS_CAR
  } obs_type_e;
  typedef enum logic [1:0] {IDLE, REQUEST, COLLECT, PUBLISH} state_e;
  function automatic logic [LANE_W-1:0] lane_of(input obstacle_t w);
    return w[LANE_LSB +: LANE_W];
  endfunction
endpackage

// File: rtl/obstacle_collector_if.sv
// obstacle_collector_if: generator handshake plus the published-frame read port
interface obstacle_collector_if #(parameter int ADDR_W = 6);
  import obstacle_pkg::*;
  logic new_frame, activate, in_valid, in_first_row, in_done;
  logic frame_ready, overflow, frame_overrun;
  obstacle_t in_obstacle, rd_data;
  logic [ADDR_W-1:0] rd_addr, obstacle_count;
  logic [LANES-1:0] front_valid;
  obstacle_t [LANES-1:0] front_obstacle;
  modport master (
    output new_frame, in_valid, in_first_row, in_obstacle, in_done, rd_addr,
    input activate, rd_data, obstacle_count, front_valid, front_obstacle,
    input frame_ready, overflow, frame_overrun
  );
  modport slave (
    input new_frame, in_valid, in_first_row, in_obstacle, in_done, rd_addr,
    output activate, rd_data, obstacle_count, front_valid, front_obstacle,
    output frame_ready, overflow, frame_overrun
  );
endinterface

// File: rtl/obstacle_bank_ram.sv
// obstacle_bank_ram: two-bank 1W/1R synchronous RAM, one bank filled while the other is read
module obstacle_bank_ram import obstacle_pkg::*; #(
  parameter int DEPTH = MAX_OBSTACLES,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  obstacle_t     wr_data,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output obstacle_t     rd_data
);
  obstacle_t mem [2*DEPTH];
  logic [AW:0] wi, ri;
  assign wi = {1'b0, wr_addr} + (wr_bank ? (AW+1)'(DEPTH) : '0);
  assign ri = {1'b0, rd_addr} + (rd_bank ? (AW+1)'(DEPTH) : '0);
  // synchronous write and registered read
  always_ff @(posedge clk) begin
    if (we) mem[wi] <= wr_data;
    rd_data <= mem[ri];
  end
endmodule

// File: rtl/obstacle_collector.sv
// obstacle_collector: requests one obstacle pass per frame, buffers it and publishes it by bank swap
module obstacle_collector #(
  parameter int MAX_OBSTACLES = obstacle_pkg::MAX_OBSTACLES,
  parameter int ADDR_W = 6
) (
  input logic clk,
  input logic rst,
  obstacle_collector_if.slave bus
);
  import obstacle_pkg::*;
  state_e state, state_nx;
  logic in_collect, publish, full, in_range, accept, bank_sel, rd_hit;
  logic [ADDR_W-1:0] wr_count;
  logic [LANES-1:0] pend_valid;
  obstacle_t [LANES-1:0] pend;
  obstacle_t ram_q;
  assign full = wr_count == ADDR_W'(MAX_OBSTACLES);
  assign in_range = lane_of(bus.in_obstacle) != 2'd3;
  assign accept = in_collect && bus.in_valid && in_range && !full;
  assign bus.rd_data = rd_hit ? ram_q : '0;
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // next state: one-cycle REQUEST and PUBLISH around an open-ended COLLECT
  always_comb state_nx = state == IDLE    ? (bus.new_frame ? REQUEST : IDLE) :
                         state == REQUEST ? COLLECT :
                         state == COLLECT ? (bus.in_done ? PUBLISH : COLLECT) : IDLE;
  // state-decoded controls
  always_comb begin
    bus.activate = state == REQUEST;
    in_collect = state == COLLECT;
    publish = state == PUBLISH;
  end
  // write count, first-row capture, bank swap, published registers and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= '0;
      pend_valid <= '0;
      pend <= '0;
      bank_sel <= 1'b0;
      rd_hit <= 1'b0;
      bus.obstacle_count <= '0;
      bus.front_valid <= '0;
      bus.front_obstacle <= '0;
      bus.frame_ready <= 1'b0;
      bus.overflow <= 1'b0;
      bus.frame_overrun <= 1'b0;
    end else begin
      bus.frame_ready <= publish;
      rd_hit <= bus.rd_addr < bus.obstacle_count;
      if (bus.new_frame && state != IDLE) bus.frame_overrun <= 1'b1;
      if (in_collect && bus.in_valid && in_range && full) bus.overflow <= 1'b1;
      if (state == IDLE && bus.new_frame) begin
        wr_count <= '0;
        pend_valid <= '0;
        pend <= '0;
      end
      if (accept) wr_count <= wr_count + 1'b1;
      for (int l = 0; l < LANES; l++)
        if (accept && bus.in_first_row && !pend_valid[l] && lane_of(bus.in_obstacle) == LANE_W'(l)) begin
          pend_valid[l] <= 1'b1;
          pend[l] <= bus.in_obstacle;
        end
      if (publish) begin
        bank_sel <= !bank_sel;
        bus.obstacle_count <= wr_count;
        bus.front_valid <= pend_valid;
        bus.front_obstacle <= pend;
      end
    end
  end
  obstacle_bank_ram #(.DEPTH(MAX_OBSTACLES), .AW(ADDR_W)) u_ram (
    .clk(clk),
    .we(accept),
    .wr_bank(!bank_sel),
    .wr_addr(wr_count),
    .wr_data(bus.in_obstacle),
    .rd_bank(bank_sel),
    .rd_addr(bus.rd_addr),
    .rd_data(ram_q)
  );
endmodule
